// File: rtl/sram_ctrl.sv
// Purpose: register-driven controller running one asynchronous SRAM read or write per go strobe.
// Latency: go at edge E0 -> busy cycles 1..WAIT_CYCLES+2, one-cycle done pulse in cycle WAIT_CYCLES+3.
// Backpressure: none; a go while busy is dropped and sets the sticky err status bit.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [15:0] cmd,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic [15:0] status,
    output logic        done,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    logic [3:0] waitCount;
    logic       isWrite;
    logic       busyFlag;
    logic       errFlag;
    logic       validFlag;

    // Only the write and clear-error bits of the command word carry meaning.
    logic       unusedCmdBits;
    assign unusedCmdBits = ^cmd[15:2];

    // Status word is a plain concatenation of registered flags.
    assign status = {13'b0, validFlag, errFlag, busyFlag};

    // Single FSM: every SRAM strobe and status flag is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            waitCount  <= 4'd0;
            isWrite    <= 1'b0;
            busyFlag   <= 1'b0;
            errFlag    <= 1'b0;
            validFlag  <= 1'b0;
            rdata      <= 16'h0000;
            done       <= 1'b0;
            sram_addr  <= 16'h0000;
            sram_dq_o  <= 16'h0000;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        if (cmd[1]) begin
                            // Clear-error command: no SRAM cycle, no done.
                            errFlag <= 1'b0;
                        end else begin
                            isWrite    <= cmd[0];
                            sram_addr  <= addr;
                            if (cmd[0]) begin
                                sram_dq_o <= wdata;
                            end
                            // Write data is driven from SETUP so it is stable before we_n falls.
                            sram_dq_oe <= cmd[0];
                            sram_ce_n  <= 1'b0;
                            busyFlag   <= 1'b1;
                            validFlag  <= 1'b0;
                            waitCount  <= WAIT_INIT;
                            state      <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (go) begin
                        errFlag <= 1'b1;
                    end
                    // Only one of the two strobes ever falls, so they never overlap.
                    if (isWrite) begin
                        sram_we_n <= 1'b0;
                    end else begin
                        sram_oe_n <= 1'b0;
                    end
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (go) begin
                        errFlag <= 1'b1;
                    end
                    if (waitCount <= 4'd1) begin
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        waitCount <= 4'd0;
                        if (!isWrite) begin
                            rdata     <= sram_dq_i;
                            validFlag <= 1'b1;
                        end
                        state <= HOLD;
                    end else begin
                        waitCount <= waitCount - 4'd1;
                    end
                end
                HOLD: begin
                    if (go) begin
                        errFlag <= 1'b1;
                    end
                    sram_ce_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                    busyFlag   <= 1'b0;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Purpose: directed scoreboard bench for sram_ctrl with WAIT_CYCLES=2 and WAIT_CYCLES=1 instances.
// Latency: done events are matched against the expected completion cycle of each queued op.
// Backpressure: stimulus waits fixed cycle counts; a watchdog bounds the whole run.
module tb_sram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    logic monOn = 1'b0;

    // Cycle counter: cycle k of an op is the interval where cyc == base+k.
    always @(posedge clk) cyc <= cyc + 1;

    logic        go2, done2, dqOe2, ceN2, oeN2, weN2;
    logic [15:0] cmd2, addr2, wdata2, rdata2, status2, sramAddr2, dqO2, dqI2;
    logic        go1, done1, dqOe1, ceN1, oeN1, weN1;
    logic [15:0] cmd1, addr1, wdata1, rdata1, status1, sramAddr1, dqO1, dqI1;

    sram_ctrl #(.WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .go(go2), .cmd(cmd2), .addr(addr2), .wdata(wdata2),
        .rdata(rdata2), .status(status2), .done(done2), .sram_addr(sramAddr2),
        .sram_dq_o(dqO2), .sram_dq_oe(dqOe2), .sram_dq_i(dqI2),
        .sram_ce_n(ceN2), .sram_oe_n(oeN2), .sram_we_n(weN2)
    );

    sram_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .go(go1), .cmd(cmd1), .addr(addr1), .wdata(wdata1),
        .rdata(rdata1), .status(status1), .done(done1), .sram_addr(sramAddr1),
        .sram_dq_o(dqO1), .sram_dq_oe(dqOe1), .sram_dq_i(dqI1),
        .sram_ce_n(ceN1), .sram_oe_n(oeN1), .sram_we_n(weN1)
    );

    // Behavioural SRAMs: write on a clock where ce_n and we_n are low, read combinationally.
    logic [15:0] mem2 [0:255];
    logic [15:0] mem1 [0:255];
    always @(posedge clk) if (!ceN2 && !weN2) mem2[sramAddr2[7:0]] <= dqO2;
    always @(posedge clk) if (!ceN1 && !weN1) mem1[sramAddr1[7:0]] <= dqO1;
    assign dqI2 = (!ceN2 && !oeN2) ? mem2[sramAddr2[7:0]] : 16'hDEAD;
    assign dqI1 = (!ceN1 && !oeN1) ? mem1[sramAddr1[7:0]] : 16'hDEAD;

    typedef struct {
        int          cycle;
        logic [15:0] rdata;
        logic [15:0] status;
    } exp_t;
    exp_t q2[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // {ce_n, we_n, oe_n, dq_oe, busy}
    function automatic logic [4:0] strobes(input int d);
        if (d == 2) return {ceN2, weN2, oeN2, dqOe2, status2[0]};
        return {ceN1, weN1, oeN1, dqOe1, status1[0]};
    endfunction

    // Monitor: protocol invariants every cycle, done pulses popped against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (monOn) begin
            chk("inv_strobes_overlap2", {31'b0, !weN2 && !oeN2}, 32'd0);
            chk("inv_oe_drive2", {31'b0, dqOe2 && !oeN2}, 32'd0);
            chk("inv_strobes_overlap1", {31'b0, !weN1 && !oeN1}, 32'd0);
            chk("inv_oe_drive1", {31'b0, dqOe1 && !oeN1}, 32'd0);
            if (done2) begin
                if (q2.size() == 0) chk("unexpected_done2", 32'd1, 32'd0);
                else begin
                    e = q2.pop_front();
                    chk("done2_cycle", cyc, e.cycle);
                    chk("done2_rdata", {16'b0, rdata2}, {16'b0, e.rdata});
                    chk("done2_status", {16'b0, status2}, {16'b0, e.status});
                end
            end
            if (done1) begin
                if (q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("done1_cycle", cyc, e.cycle);
                    chk("done1_rdata", {16'b0, rdata1}, {16'b0, e.rdata});
                    chk("done1_status", {16'b0, status1}, {16'b0, e.status});
                end
            end
        end
    end

    // Drive go for one edge; base is chosen so cycle k after the go edge has cyc == base+k.
    task automatic issue(input int d, input logic [15:0] c, input logic [15:0] a,
                         input logic [15:0] w, output int base);
        @(negedge clk);
        if (d == 2) begin go2 = 1'b1; cmd2 = c; addr2 = a; wdata2 = w; end
        else        begin go1 = 1'b1; cmd1 = c; addr1 = a; wdata1 = w; end
        @(posedge clk);
        #1;
        go2 = 1'b0;
        go1 = 1'b0;
        base = cyc - 1;
    endtask

    // Full op: queue the expected done event, then check strobes through the busy cycles.
    task automatic runOp(input int d, input logic [15:0] c, input logic [15:0] a,
                         input logic [15:0] w, input logic [15:0] expRd,
                         input logic expErr, input int wc);
        int          base;
        logic        wr;
        logic        act;
        logic [4:0]  exp;
        wr = c[0];
        issue(d, c, a, w, base);
        if (d == 2) q2.push_back('{base + wc + 3, expRd, {13'b0, !wr, expErr, 1'b0}});
        else        q1.push_back('{base + wc + 3, expRd, {13'b0, !wr, expErr, 1'b0}});
        for (int k = 1; k <= wc + 2; k++) begin
            @(negedge clk);
            act = (k >= 2) && (k <= wc + 1);
            exp = {1'b0, !(wr && act), !(!wr && act), wr, 1'b1};
            chk($sformatf("strobes_d%0d_k%0d", d, k), {27'b0, strobes(d)}, {27'b0, exp});
            chk("sram_addr", {16'b0, (d == 2) ? sramAddr2 : sramAddr1}, {16'b0, a});
            if (wr) chk("sram_dq_o", {16'b0, (d == 2) ? dqO2 : dqO1}, {16'b0, w});
            if (!wr && k == wc + 2) begin
                chk("rdata_in_hold", {16'b0, (d == 2) ? rdata2 : rdata1}, {16'b0, expRd});
                chk("valid_in_hold", {31'b0, (d == 2) ? status2[2] : status1[2]}, 32'd1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b1;
        go2 = 1'b0; cmd2 = '0; addr2 = '0; wdata2 = '0;
        go1 = 1'b0; cmd1 = '0; addr1 = '0; wdata1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        // Reset state
        chk("rst_strobes2", {27'b0, strobes(2)}, {27'b0, 5'b11100});
        chk("rst_status2", {16'b0, status2}, 32'd0);
        chk("rst_rdata2", {16'b0, rdata2}, 32'd0);
        chk("rst_addr2", {16'b0, sramAddr2}, 32'd0);
        chk("rst_dq_o2", {16'b0, dqO2}, 32'd0);
        chk("rst_done2", {31'b0, done2}, 32'd0);
        chk("rst_strobes1", {27'b0, strobes(1)}, {27'b0, 5'b11100});
        chk("rst_status1", {16'b0, status1}, 32'd0);
        reset = 1'b0;
        monOn = 1'b1;

        // Write 0xBEEF to 0x0123, then read it back.
        runOp(2, 16'h0001, 16'h0123, 16'hBEEF, 16'h0000, 1'b0, 2);
        runOp(2, 16'h0000, 16'h0123, 16'h0000, 16'hBEEF, 1'b0, 2);

        // go in cycle 2 of a write is ignored but sets err.
        fork
            runOp(2, 16'h0001, 16'h0124, 16'hA5A5, 16'hBEEF, 1'b1, 2);
            begin
                @(negedge clk);
                @(posedge clk);
                #1;
                @(negedge clk);
                @(negedge clk);
                go2 = 1'b1; cmd2 = 16'h0000; addr2 = 16'h0055;
                @(posedge clk);
                #1;
                go2 = 1'b0;
            end
        join
        chk("mem_after_ignored_go", {16'b0, mem2[8'h24]}, 32'h0000A5A5);
        // Clear error: no strobes, no done.
        issue(2, 16'h0002, 16'h0099, 16'h0000, base);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("clr_strobes", {27'b0, strobes(2)}, {27'b0, 5'b11100});
            chk("clr_status", {16'b0, status2}, 32'd0);
        end

        // Back-to-back: read issued in the write's done cycle.
        runOp(2, 16'h0001, 16'h0042, 16'h1234, 16'hBEEF, 1'b0, 2);
        runOp(2, 16'h0000, 16'h0042, 16'h0000, 16'h1234, 1'b0, 2);

        // Reset during cycle 2 of a write aborts with no done.
        issue(2, 16'h0001, 16'h0077, 16'h5555, base);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_strobes", {27'b0, strobes(2)}, {27'b0, 5'b11100});
        chk("abort_status", {16'b0, status2}, 32'd0);
        chk("abort_rdata", {16'b0, rdata2}, 32'd0);
        repeat (8) @(negedge clk);

        // WAIT_CYCLES=1 instance: write then read.
        runOp(1, 16'h0001, 16'h0010, 16'hC0DE, 16'h0000, 1'b0, 1);
        runOp(1, 16'h0000, 16'h0010, 16'h0000, 16'hC0DE, 1'b0, 1);

        repeat (4) @(negedge clk);
        chk("q2_drained", q2.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
